// File: rtl/seq_alu_cu_if.sv
// Handshake and result bus of the sequenced ALU control unit.
// master = instruction producer / result consumer, slave = seq_alu_cu.
interface seq_alu_cu_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [3+2*W-1:0]   instr;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       result;
    logic               carry;
    logic               zero;
    logic [CNT_W-1:0]   op_count;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, result, carry, zero, op_count
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, result, carry, zero, op_count
    );
endinterface

// File: rtl/seq_alu_cu.sv
// Multi-cycle ALU control unit: IDLE -> EXEC -> RESP with valid/ready on both sides.
// Define SEQ_ALU_CU_ACC_EN to add the accumulator and make opcode 000 compute acc+b.
module seq_alu_cu #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_alu_cu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    state_t         state;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W:0]     alu_w;
`ifdef SEQ_ALU_CU_ACC_EN
    logic [W-1:0]   acc_q;
`endif

    // Bit W carries out of ADD/INC and, with W+1-bit subtraction, is the borrow of SUB/DEC.
    always_comb begin
        // NOTE: default first so every path assigns alu_w and no latch is inferred.
        alu_w = '0;
        case (op_q)
            OP_ADD:  alu_w = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu_w = {1'b0, a_q} - {1'b0, b_q};
            OP_INC:  alu_w = {1'b0, a_q} + ONE;
            OP_DEC:  alu_w = {1'b0, a_q} - ONE;
            OP_AND:  alu_w = {1'b0, a_q & b_q};
            OP_OR:   alu_w = {1'b0, a_q | b_q};
            OP_NOT:  alu_w = {1'b0, ~a_q};
`ifdef SEQ_ALU_CU_ACC_EN
            default: alu_w = {1'b0, acc_q} + {1'b0, b_q};
`else
            default: alu_w = '0;
`endif
        endcase
    end

    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.carry     <= 1'b0;
            bus.zero      <= 1'b0;
            bus.op_count  <= '0;
`ifdef SEQ_ALU_CU_ACC_EN
            acc_q         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        {op_q, a_q, b_q} <= bus.instr;
                        bus.in_ready     <= 1'b0;
                        state            <= EXEC;
                    end
                end
                EXEC: begin
                    bus.result    <= alu_w[W-1:0];
                    bus.carry     <= alu_w[W];
                    bus.zero      <= (alu_w[W-1:0] == '0);
                    bus.out_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    // in_ready rises only after the handoff edge, so RESP never accepts.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.op_count  <= bus.op_count + CNT_W'(1);
`ifdef SEQ_ALU_CU_ACC_EN
                        acc_q         <= bus.result;
`endif
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
